// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
//   Shared constants for the execute stage of the 5-stage ARM pipeline:
//   ALU command codes, NZCV bit positions and operand-forward select codes.
// ---------------------------------------------------------------------------
package arm_pkg;

   typedef logic [3:0] exe_cmd_t;

   // ALU command codes produced by the controller
   localparam exe_cmd_t MOV_EXE = 4'b0001;
   localparam exe_cmd_t MVN_EXE = 4'b1001;
   localparam exe_cmd_t ADD_EXE = 4'b0010;  // also LDR/STR address generation
   localparam exe_cmd_t ADC_EXE = 4'b0011;
   localparam exe_cmd_t SUB_EXE = 4'b0100;
   localparam exe_cmd_t SBC_EXE = 4'b0101;
   localparam exe_cmd_t AND_EXE = 4'b0110;
   localparam exe_cmd_t ORR_EXE = 4'b0111;
   localparam exe_cmd_t EOR_EXE = 4'b1000;
   localparam exe_cmd_t CMP_EXE = SUB_EXE;
   localparam exe_cmd_t TST_EXE = AND_EXE;

   // Bit positions inside the 4-bit {N,Z,C,V} status word
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Operand forward selects (11 behaves like 00)
   localparam logic [1:0] SEL_REG     = 2'b00;
   localparam logic [1:0] SEL_MEM     = 2'b01;
   localparam logic [1:0] SEL_WB      = 2'b10;
   localparam logic [1:0] SEL_REG_ALT = 2'b11;

endpackage : arm_pkg

// File: rtl/exe_stage_alu.sv
// ---------------------------------------------------------------------------
// alu
//   Purely combinational ALU of the execute stage.
//   Ports:
//     exe_cmd     in   4     command code (arm_pkg::*_EXE)
//     a, b        in   XLEN  operands (rn, shifted val2)
//     c, v        in   1     current C and V status bits
//     result      out  XLEN  ALU result (0 for unknown commands)
//     nzcv        out  4     next {N,Z,C,V}
//     flags_valid out  1     0 for unknown commands: status must not change
// ---------------------------------------------------------------------------
module alu
   import arm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [3:0]      exe_cmd,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            c,
   input  logic            v,
   output logic [XLEN-1:0] result,
   output logic [3:0]      nzcv,
   output logic            flags_valid
);

   logic [XLEN:0] w_sum;
   logic          w_arith;
   logic          w_sub;
   logic          w_c_out;
   logic          w_v_out;
   logic [XLEN:0] w_cin;
   logic [XLEN:0] w_one;

   assign w_cin = {{XLEN{1'b0}}, c};
   assign w_one = {{XLEN{1'b0}}, 1'b1};

   always_comb begin
      w_sum       = '0;
      w_arith     = 1'b0;
      w_sub       = 1'b0;
      result      = '0;
      flags_valid = 1'b1;
      case (exe_cmd)
         MOV_EXE: result = b;
         MVN_EXE: result = ~b;
         ADD_EXE: begin
            w_sum   = {1'b0, a} + {1'b0, b};
            w_arith = 1'b1;
         end
         ADC_EXE: begin
            w_sum   = {1'b0, a} + {1'b0, b} + w_cin;
            w_arith = 1'b1;
         end
         // Subtractions go through the adder so bit XLEN is "no borrow".
         SUB_EXE: begin
            w_sum   = {1'b0, a} + {1'b0, ~b} + w_one;
            w_arith = 1'b1;
            w_sub   = 1'b1;
         end
         SBC_EXE: begin
            w_sum   = {1'b0, a} + {1'b0, ~b} + w_cin;
            w_arith = 1'b1;
            w_sub   = 1'b1;
         end
         AND_EXE: result = a & b;
         ORR_EXE: result = a | b;
         EOR_EXE: result = a ^ b;
         default: flags_valid = 1'b0;
      endcase
      if (w_arith) begin
         result = w_sum[XLEN-1:0];
      end
   end

   // Logical and move commands keep the incoming C and V.
   always_comb begin
      w_c_out = c;
      w_v_out = v;
      if (w_arith) begin
         w_c_out = w_sum[XLEN];
         if (w_sub) begin
            w_v_out = (a[XLEN-1] != b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
         end else begin
            w_v_out = (a[XLEN-1] == b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
         end
      end
   end

   always_comb begin
      nzcv         = '0;
      nzcv[FLAG_N] = result[XLEN-1];
      nzcv[FLAG_Z] = (result == '0);
      nzcv[FLAG_C] = w_c_out;
      nzcv[FLAG_V] = w_v_out;
   end

endmodule : alu

// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage
//   Execute stage of the 5-stage ARM pipeline: ID/EXE pipeline register,
//   ALU, NZCV status register and branch-target adder. ALU result and
//   controls feed the EXE/MEM register combinationally; status goes back
//   to the decode-stage condition check.
//
//   Optional feature: define EXE_FORWARD_EN to add operand forwarding
//   (sel_src1/sel_src2 selects, mem_fwd/wb_fwd data).
//
//   Ports:
//     clk, rst               clock, asynchronous active-low reset
//     flush, freeze          bubble insert (wins) / hold ID/EXE register
//     exe_cmd_in, *_in       decoded control word and operands
//     alu_result             ALU result / memory address
//     store_data, dest       registered store data / destination
//     mem_read, mem_write,
//     wb_en, branch_taken    registered controls
//     branch_addr            pc + sign-extended imm24 << 2
//     status                 registered {N,Z,C,V}
// ---------------------------------------------------------------------------
module exe_stage
   import arm_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              freeze,
   input  logic [3:0]        exe_cmd_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic              wb_en_in,
   input  logic              s_in,
   input  logic              b_in,
   input  logic [XLEN-1:0]   pc_in,
   input  logic [XLEN-1:0]   val_rn_in,
   input  logic [XLEN-1:0]   val2_in,
   input  logic [XLEN-1:0]   val_rm_in,
   input  logic [23:0]       imm24_in,
   input  logic [REG_AW-1:0] dest_in,
`ifdef EXE_FORWARD_EN
   input  logic [1:0]        sel_src1,
   input  logic [1:0]        sel_src2,
   input  logic [XLEN-1:0]   mem_fwd,
   input  logic [XLEN-1:0]   wb_fwd,
`endif
   output logic [XLEN-1:0]   alu_result,
   output logic [XLEN-1:0]   store_data,
   output logic [REG_AW-1:0] dest,
   output logic              mem_read,
   output logic              mem_write,
   output logic              wb_en,
   output logic              branch_taken,
   output logic [XLEN-1:0]   branch_addr,
   output logic [3:0]        status
);

   // ID/EXE register fields
   logic [3:0]        r_exe_cmd;
   logic              r_mem_read;
   logic              r_mem_write;
   logic              r_wb_en;
   logic              r_s;
   logic              r_b;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_val_rn;
   logic [XLEN-1:0]   r_val2;
   logic [XLEN-1:0]   r_val_rm;
   logic [23:0]       r_imm24;
   logic [REG_AW-1:0] r_dest;

   logic [3:0]        r_status;

   logic [XLEN-1:0]   w_op_a;
   logic [XLEN-1:0]   w_store;
   logic [XLEN-1:0]   w_alu_result;
   logic [3:0]        w_alu_nzcv;
   logic              w_alu_valid;
   logic              w_status_we;

   // A flush clears only the control word; data fields still load so the
   // bubble carries harmless values rather than stale ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_exe_cmd   <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_wb_en     <= 1'b0;
         r_s         <= 1'b0;
         r_b         <= 1'b0;
         r_pc        <= '0;
         r_val_rn    <= '0;
         r_val2      <= '0;
         r_val_rm    <= '0;
         r_imm24     <= '0;
         r_dest      <= '0;
      end else if (flush || !freeze) begin
         r_exe_cmd   <= flush ? 4'b0000 : exe_cmd_in;
         r_mem_read  <= mem_read_in  & ~flush;
         r_mem_write <= mem_write_in & ~flush;
         r_wb_en     <= wb_en_in     & ~flush;
         r_s         <= s_in         & ~flush;
         r_b         <= b_in         & ~flush;
         r_pc        <= pc_in;
         r_val_rn    <= val_rn_in;
         r_val2      <= val2_in;
         r_val_rm    <= val_rm_in;
         r_imm24     <= imm24_in;
         r_dest      <= dest_in;
      end
   end

`ifdef EXE_FORWARD_EN
   always_comb begin
      w_op_a = r_val_rn;
      case (sel_src1)
         SEL_MEM: w_op_a = mem_fwd;
         SEL_WB:  w_op_a = wb_fwd;
         default: w_op_a = r_val_rn;
      endcase
   end

   // Store data is only forwarded for stores; val2 is never forwarded
   // because it is an immediate or an already-shifted register value.
   always_comb begin
      w_store = r_val_rm;
      if (r_mem_write) begin
         case (sel_src2)
            SEL_MEM: w_store = mem_fwd;
            SEL_WB:  w_store = wb_fwd;
            default: w_store = r_val_rm;
         endcase
      end
   end
`else
   assign w_op_a  = r_val_rn;
   assign w_store = r_val_rm;
`endif

   alu #(
      .XLEN(XLEN)
   ) u_alu (
      .exe_cmd     (r_exe_cmd),
      .a           (w_op_a),
      .b           (r_val2),
      .c           (r_status[FLAG_C]),
      .v           (r_status[FLAG_V]),
      .result      (w_alu_result),
      .nzcv        (w_alu_nzcv),
      .flags_valid (w_alu_valid)
   );

   // The S bit is reused by memory and branch encodings, so only plain
   // data-processing instructions may write the flags. Freeze does not
   // gate this: the instruction in EXE completes regardless.
   assign w_status_we = r_s & ~r_mem_read & ~r_mem_write & ~r_b & w_alu_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_status <= 4'b0000;
      end else if (w_status_we) begin
         r_status <= w_alu_nzcv;
      end
   end

   assign alu_result   = w_alu_result;
   assign store_data   = w_store;
   assign dest         = r_dest;
   assign mem_read     = r_mem_read;
   assign mem_write    = r_mem_write;
   assign wb_en        = r_wb_en;
   assign branch_taken = r_b;
   assign branch_addr  = r_pc + {{(XLEN-26){r_imm24[23]}}, r_imm24, 2'b00};
   assign status       = r_status;

endmodule : exe_stage

// File: tb/tb_exe_stage.sv
// ---------------------------------------------------------------------------
// tb_exe_stage
//   Directed bench for exe_stage: a table of single-instruction vectors
//   (inputs plus hand-computed result/branch/status) followed by short
//   hand-written sequences for flush, freeze, back-to-back flag setters,
//   forwarding (EXE_FORWARD_EN) and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_exe_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        freeze;
   logic [3:0]  exe_cmd_in;
   logic        mem_read_in, mem_write_in, wb_en_in, s_in, b_in;
   logic [31:0] pc_in, val_rn_in, val2_in, val_rm_in;
   logic [23:0] imm24_in;
   logic [3:0]  dest_in;
`ifdef EXE_FORWARD_EN
   logic [1:0]  sel_src1, sel_src2;
   logic [31:0] mem_fwd, wb_fwd;
`endif
   logic [31:0] alu_result, store_data, branch_addr;
   logic [3:0]  dest, status;
   logic        mem_read, mem_write, wb_en, branch_taken;

   int n_cmp = 0;
   int n_err = 0;

   exe_stage #(.XLEN(32), .REG_AW(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .freeze       (freeze),
      .exe_cmd_in   (exe_cmd_in),
      .mem_read_in  (mem_read_in),
      .mem_write_in (mem_write_in),
      .wb_en_in     (wb_en_in),
      .s_in         (s_in),
      .b_in         (b_in),
      .pc_in        (pc_in),
      .val_rn_in    (val_rn_in),
      .val2_in      (val2_in),
      .val_rm_in    (val_rm_in),
      .imm24_in     (imm24_in),
      .dest_in      (dest_in),
`ifdef EXE_FORWARD_EN
      .sel_src1     (sel_src1),
      .sel_src2     (sel_src2),
      .mem_fwd      (mem_fwd),
      .wb_fwd       (wb_fwd),
`endif
      .alu_result   (alu_result),
      .store_data   (store_data),
      .dest         (dest),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .wb_en        (wb_en),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .status       (status)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish within 200000");
      $fatal(1, "timeout");
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0]  cmd;
      logic        mr, mw, wb, s, b;
      logic [31:0] pc, rn, v2, rm;
      logic [23:0] imm;
      logic [3:0]  dst;
      logic [31:0] exp_res;
      logic [31:0] exp_baddr;
      logic [3:0]  exp_status;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic [3:0] cmd, input logic mr, mw, wb, s, b,
                               input logic [31:0] pc, rn, v2, rm, input logic [23:0] imm,
                               input logic [3:0] dst, input logic [31:0] exp_res,
                               input logic [31:0] exp_baddr, input logic [3:0] exp_status);
      vec_t v;
      v.cmd = cmd; v.mr = mr; v.mw = mw; v.wb = wb; v.s = s; v.b = b;
      v.pc = pc; v.rn = rn; v.v2 = v2; v.rm = rm; v.imm = imm; v.dst = dst;
      v.exp_res = exp_res; v.exp_baddr = exp_baddr; v.exp_status = exp_status;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [3:0] cmd, input logic mr, mw, wb, s, b,
                        input logic [31:0] pc, rn, v2, rm, input logic [23:0] imm,
                        input logic [3:0] dst);
      exe_cmd_in   = cmd;
      mem_read_in  = mr;
      mem_write_in = mw;
      wb_en_in     = wb;
      s_in         = s;
      b_in         = b;
      pc_in        = pc;
      val_rn_in    = rn;
      val2_in      = v2;
      val_rm_in    = rm;
      imm24_in     = imm;
      dest_in      = dst;
   endtask

   task automatic drive_nop();
      drive(4'b0000, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 24'h0, 4'h0);
   endtask

   // one edge, then sample 1 time unit after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard compare ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- test ----------------
   initial begin
      //             cmd    mr mw wb s  b  pc            rn            v2            rm            imm        dst   exp_res       exp_baddr     st
      vecs[0]  = mk(4'h2, 0, 0, 1, 1, 0, 32'h0,        32'h7FFFFFFF, 32'h1,        32'h0,        24'h0,     4'h1, 32'h80000000, 32'h0,        4'b1001);
      vecs[1]  = mk(4'h4, 0, 0, 0, 1, 0, 32'h0,        32'h5,        32'h5,        32'h0,        24'h0,     4'h0, 32'h0,        32'h0,        4'b0110);
      vecs[2]  = mk(4'h5, 0, 0, 1, 1, 0, 32'h0,        32'd10,       32'd3,        32'h0,        24'h0,     4'h2, 32'd7,        32'h0,        4'b0010);
      vecs[3]  = mk(4'h2, 0, 1, 0, 0, 0, 32'h200,      32'h1000,     32'h8,        32'hDEAD,     24'h10,    4'h0, 32'h1008,     32'h240,      4'b0010);
      vecs[4]  = mk(4'h2, 0, 1, 0, 1, 0, 32'h0,        32'h3000,     32'hC,        32'hBEEF,     24'h0,     4'h0, 32'h300C,     32'h0,        4'b0010);
      vecs[5]  = mk(4'h2, 1, 0, 1, 1, 0, 32'h0,        32'h2000,     32'h4,        32'h0,        24'h0,     4'h4, 32'h2004,     32'h0,        4'b0010);
      vecs[6]  = mk(4'h6, 0, 0, 0, 1, 0, 32'h0,        32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0,        24'h0,     4'h0, 32'h0,        32'h0,        4'b0110);
      vecs[7]  = mk(4'h7, 0, 0, 1, 1, 0, 32'h0,        32'h80000000, 32'h1,        32'h0,        24'h0,     4'h5, 32'h80000001, 32'h0,        4'b1010);
      vecs[8]  = mk(4'h8, 0, 0, 1, 0, 0, 32'h0,        32'hFFFF0000, 32'hFFFFFFFF, 32'h0,        24'h0,     4'h6, 32'h0000FFFF, 32'h0,        4'b1010);
      vecs[9]  = mk(4'h1, 0, 0, 1, 1, 0, 32'h0,        32'h12345678, 32'h0,        32'h0,        24'h0,     4'h7, 32'h0,        32'h0,        4'b0110);
      vecs[10] = mk(4'h9, 0, 0, 1, 1, 0, 32'h0,        32'h0,        32'h0,        32'h0,        24'h0,     4'h8, 32'hFFFFFFFF, 32'h0,        4'b1010);
      vecs[11] = mk(4'h3, 0, 0, 1, 1, 0, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h0,        24'h0,     4'h9, 32'h0,        32'h0,        4'b0110);
      vecs[12] = mk(4'h4, 0, 0, 1, 1, 0, 32'h0,        32'h0,        32'h1,        32'h0,        24'h0,     4'hA, 32'hFFFFFFFF, 32'h0,        4'b1000);
      vecs[13] = mk(4'h5, 0, 0, 1, 1, 0, 32'h0,        32'd10,       32'd3,        32'h0,        24'h0,     4'hB, 32'd6,        32'h0,        4'b0010);
      vecs[14] = mk(4'h4, 0, 0, 1, 1, 0, 32'h0,        32'h80000000, 32'h1,        32'h0,        24'h0,     4'hC, 32'h7FFFFFFF, 32'h0,        4'b0011);
      vecs[15] = mk(4'hF, 0, 0, 1, 1, 0, 32'h0,        32'h5,        32'h6,        32'h0,        24'h0,     4'hD, 32'h0,        32'h0,        4'b0011);
      vecs[16] = mk(4'h2, 0, 0, 0, 1, 1, 32'h100,      32'h1,        32'h1,        32'h0,        24'hFFFFFE, 4'h0, 32'h2,        32'hF8,       4'b0011);
      vecs[17] = mk(4'h2, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h0,        24'h000001, 4'h0, 32'h0,        32'h0,        4'b0011);

      // reset state
      rst = 1'b0; flush = 1'b0; freeze = 1'b0;
`ifdef EXE_FORWARD_EN
      sel_src1 = 2'b00; sel_src2 = 2'b00; mem_fwd = 32'h0; wb_fwd = 32'h0;
`endif
      drive_nop();
      step(); step();
      chk("rst_status", {28'h0, status}, 32'h0);
      chk("rst_wb_en", {31'h0, wb_en}, 32'h0);
      chk("rst_branch_taken", {31'h0, branch_taken}, 32'h0);
      chk("rst_result", alu_result, 32'h0);
      rst = 1'b1;

      // table: capture, check combinational outputs, then bubble and check flags
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].cmd, vecs[i].mr, vecs[i].mw, vecs[i].wb, vecs[i].s, vecs[i].b,
               vecs[i].pc, vecs[i].rn, vecs[i].v2, vecs[i].rm, vecs[i].imm, vecs[i].dst);
         step();
         chk($sformatf("v%0d_result", i), alu_result, vecs[i].exp_res);
         chk($sformatf("v%0d_baddr", i), branch_addr, vecs[i].exp_baddr);
         chk($sformatf("v%0d_taken", i), {31'h0, branch_taken}, {31'h0, vecs[i].b});
         chk($sformatf("v%0d_wb_en", i), {31'h0, wb_en}, {31'h0, vecs[i].wb});
         chk($sformatf("v%0d_mem_rd", i), {31'h0, mem_read}, {31'h0, vecs[i].mr});
         chk($sformatf("v%0d_mem_wr", i), {31'h0, mem_write}, {31'h0, vecs[i].mw});
         chk($sformatf("v%0d_store", i), store_data, vecs[i].rm);
         chk($sformatf("v%0d_dest", i), {28'h0, dest}, {28'h0, vecs[i].dst});
         drive_nop();
         step();
         chk($sformatf("v%0d_status", i), {28'h0, status}, {28'h0, vecs[i].exp_status});
      end
      // status is 0011 here

      // branch then flush bubble
      drive(4'h0, 0, 0, 0, 0, 1, 32'h100, 32'h0, 32'h0, 32'h0, 24'hFFFFFE, 4'h0);
      step();
      chk("br_taken", {31'h0, branch_taken}, 32'h1);
      chk("br_addr", branch_addr, 32'hF8);
      drive(4'h2, 1, 0, 1, 1, 0, 32'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 24'h0, 4'h5);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_wb_en", {31'h0, wb_en}, 32'h0);
      chk("flush_mem_rd", {31'h0, mem_read}, 32'h0);
      chk("flush_taken", {31'h0, branch_taken}, 32'h0);
      chk("flush_dest", {28'h0, dest}, 32'h5);
      chk("flush_result", alu_result, 32'h0);
      drive_nop();
      step();
      chk("flush_status", {28'h0, status}, 32'h3);

      // freeze holds for 3 cycles while inputs change
      drive(4'h2, 0, 0, 1, 0, 0, 32'h0, 32'h1, 32'h2, 32'h0, 24'h0, 4'h3);
      step();
      freeze = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(4'h4, 0, 0, 0, 0, 0, 32'h0, $urandom_range(100, 200), $urandom_range(1, 50),
               32'h0, 24'h0, 4'(k + 10));
         step();
         chk($sformatf("frz%0d_result", k), alu_result, 32'h3);
         chk($sformatf("frz%0d_dest", k), {28'h0, dest}, 32'h3);
         chk($sformatf("frz%0d_wb_en", k), {31'h0, wb_en}, 32'h1);
      end

      // flush together with freeze acts as flush
      drive(4'h2, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 24'h0, 4'h9);
      flush = 1'b1;
      step();
      flush = 1'b0;
      freeze = 1'b0;
      chk("flzfrz_wb_en", {31'h0, wb_en}, 32'h0);
      chk("flzfrz_dest", {28'h0, dest}, 32'h9);

      // freeze does not block the status write of the instruction in EXE
      drive(4'h4, 0, 0, 1, 1, 0, 32'h0, 32'h0, 32'h1, 32'h0, 24'h0, 4'h1);
      step();
      freeze = 1'b1;
      drive_nop();
      step();
      chk("frz_status", {28'h0, status}, 32'h8);
      freeze = 1'b0;
      step();

      // back-to-back flag setters
      drive(4'h2, 0, 0, 1, 1, 0, 32'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 24'h0, 4'h1);
      step();
      drive(4'h4, 0, 0, 0, 1, 0, 32'h0, 32'h5, 32'h5, 32'h0, 24'h0, 4'h0);
      step();
      chk("b2b_status1", {28'h0, status}, 32'h9);
      drive_nop();
      step();
      chk("b2b_status2", {28'h0, status}, 32'h6);

`ifdef EXE_FORWARD_EN
      // forwarding muxes
      drive(4'h2, 0, 1, 0, 0, 0, 32'h0, 32'h99, 32'h1, 32'h77, 24'h0, 4'h0);
      step();
      mem_fwd = 32'h10; wb_fwd = 32'h20;
      sel_src1 = 2'b01; #1;
      chk("fwd_mem", alu_result, 32'h11);
      sel_src1 = 2'b10; #1;
      chk("fwd_wb", alu_result, 32'h21);
      sel_src1 = 2'b11; #1;
      chk("fwd_reg", alu_result, 32'h9A);
      sel_src2 = 2'b10; #1;
      chk("fwd_store", store_data, 32'h20);
      drive(4'h2, 0, 0, 0, 0, 0, 32'h0, 32'h99, 32'h1, 32'h77, 24'h0, 4'h0);
      step();
      chk("fwd_store_nowr", store_data, 32'h77);
      sel_src1 = 2'b00; sel_src2 = 2'b00;
`endif

      // asynchronous reset mid-operation
      drive(4'h2, 0, 0, 1, 1, 0, 32'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 24'h0, 4'h1);
      step();
      step();
      chk("pre_rst_status", {28'h0, status}, 32'h9);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_status", {28'h0, status}, 32'h0);
      chk("async_rst_wb_en", {31'h0, wb_en}, 32'h0);
      chk("async_rst_result", alu_result, 32'h0);
      chk("async_rst_dest", {28'h0, dest}, 32'h0);
      #3;
      rst = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_exe_stage

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage ARM pipeline. It holds the ID/EXE pipeline register, which captures the decoded control word (`exe_cmd`, `mem_read`, `mem_write`, `wb_en`, `S`, `B`) and the operands from the decode stage. It also contains the 32-bit ALU, the NZCV status register and branch-target generation. Results and controls go straight to the EXE/MEM register; the status flags go back to the decode-stage condition check.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `REG_AW`, 4, register-index width

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `flush`  in  1  insert a bubble on this edge (taken branch)
- `freeze`  in  1  hold the ID/EXE register
- `exe_cmd_in`  in  4  ALU command from the controller
- `mem_read_in`, `mem_write_in`, `wb_en_in`, `s_in`, `b_in`  in  1 each  controls from the controller, already zeroed upstream when the condition fails
- `pc_in`  in  XLEN  PC+4 of the instruction
- `val_rn_in`  in  XLEN  first operand
- `val2_in`  in  XLEN  shifted second operand
- `val_rm_in`  in  XLEN  store data
- `imm24_in`  in  24  branch offset
- `dest_in`  in  REG_AW  destination register
- `alu_result`  out  XLEN  ALU result or memory address
- `store_data`  out  XLEN  registered `val_rm`
- `dest`  out  REG_AW  registered destination
- `mem_read`, `mem_write`, `wb_en`  out  1 each  registered controls
- `branch_taken`  out  1  registered `b`
- `branch_addr`  out  XLEN  pc + (sign-extended imm24 << 2)
- `status`  out  4  registered {N,Z,C,V}

## Operation
- **ID/EXE register:** captures every input on the rising edge.
  - `flush` has priority over `freeze`.
  - `flush`=1: the controls (`mem_read`, `mem_write`, `wb_en`, `s`, `b`) and `exe_cmd` load 0; the data fields load normally.
  - `freeze`=1 with `flush`=0: every field holds.
- **exe_cmd encoding:** MOV=0001, MVN=1001, ADD=0010, ADC=0011, SUB=0100, SBC=0101, AND=0110, ORR=0111, EOR=1000. CMP shares SUB and TST shares AND. Loads and stores use ADD. Any other code gives result 0 and no flag change.
- **ALU:** `a` = rn, `b` = val2, `c` = status C.
  - ADC: `a+b+c`.
  - SUB: `a-b`, computed as `a+~b+1`.
  - SBC: `a-b-!c`, computed as `a+~b+c`.
  - MOV: `b`. MVN: `~b`.
- **Arithmetic flags:** computed on a 33-bit sum.
  - C = bit 32, i.e. "no borrow" for subtractions.
  - V = operands have the same sign (addition) or opposite signs (subtraction) and the result sign differs.
- **Logical and move ops:** C and V keep their previous values.
- **N and Z:** N = result[31]; Z = (result == 0).
- **Status update:** on the clock edge when the registered `s`=1, `mem_read`=0, `mem_write`=0 and `b`=0. This gate is needed because the S bit also appears in memory mode. Otherwise the status holds.
- **Branch:** `branch_addr` = registered pc + {{6{imm24[23]}}, imm24, 2'b00}, with wrap-around modulo 2^32. `branch_taken` equals the registered `b`.

## Timing
- Reset (`rst`=0, asynchronous): all registered fields go to 0. So `status`=0000, the controls are 0 and the data outputs are 0.
- Latency: an input captured at edge k appears on the outputs after edge k, combinationally through the ALU.
- The status update from an instruction is visible one cycle after that instruction's EXE cycle. The consumer is the next instruction to reach decode.
- `flush` and `freeze` asserted together act as `flush`.
- `freeze` does not block the status write of the instruction currently in EXE. That instruction still completes.
- Back-to-back flag setters each update the status in turn, with no stall.

## Configuration
- Macro `EXE_FORWARD_EN`.
- **Defined:**
  - Added ports: `sel_src1` and `sel_src2` (in, 2 bits), `mem_fwd` and `wb_fwd` (in, XLEN).
  - `sel` values: 00 = registered operand, 01 = `mem_fwd`, 10 = `wb_fwd`, 11 = registered operand.
  - `sel_src2` replaces `val_rm` for `store_data` only when `mem_write`=1. `val2` is never forwarded because it is an immediate or an already-shifted value.
- **Undefined:** the ports do not exist and the ALU uses the registered operands only.

## Structure
- Package `arm_pkg` holds:
  - the `exe_cmd` codes (`MOV_EXE` … `EOR_EXE`, with `CMP_EXE`=`SUB_EXE` and `TST_EXE`=`AND_EXE`);
  - the flag bit indices N=3, Z=2, C=1, V=0;
  - the forward-select codes.
- Sub-module `alu`: purely combinational, taking `exe_cmd`, `a`, `b` and `c` and producing the result and {N,Z,C,V}.

## Test plan
- Reset mid-operation: assert `rst`=0 with live inputs → `status`=0000 and `wb_en`=0 at once, without waiting for a clock edge.
- ADD with `s`=1, rn=0x7FFFFFFF, val2=1 → result 0x80000000, status N=1 Z=0 C=0 V=1.
- CMP (SUB, `wb_en`=0, `s`=1), rn=5, val2=5 → result 0, status Z=1 C=1. Then SBC 10−3 with C=1 → 7.
- STR with `s`=0 then LDR with `s`=1 → status unchanged after both. LDR has `mem_read`=1 and `alu_result`=rn+val2.
- Branch: pc=0x100, imm24=0xFFFFFE → `branch_taken`=1, `branch_addr`=0xF8. Next edge with `flush`=1 and `wb_en_in`=1 → `wb_en`=0.
- `freeze`=1 for 3 cycles with changing inputs → outputs hold. `EXE_FORWARD_EN` with `sel_src1`=01 and `mem_fwd`=0x10 → ADD uses 0x10.
